voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/dispatcher_pkg.sv | 20 ++
 rtl/search.sv | 25 ++
 rtl/voice_allocator.sv | 169 ++++++++++++++++
 tb/tb_voice_allocator.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared allocator state and note event types
package dispatcher_pkg;

    // Field widths of a stored note event; they track the allocator's default MIDI widths.
    localparam int EV_NOTE_WIDTH     = 7;
    localparam int EV_VELOCITY_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_COMMIT = 2'd2
    } alloc_state_e;

    typedef struct packed {
        logic                         is_on;
        logic [EV_NOTE_WIDTH-1:0]     note;
        logic [EV_VELOCITY_WIDTH-1:0] velocity;
    } note_event_t;

endpackage

// File: rtl/search.sv
// rtl/search.sv - lowest-index equality lookup over a packed element array
module search #(
    parameter int ELEMENT_WIDTH = 1,
    parameter int COUNT         = 4,
    localparam int IDX_W        = $clog2(COUNT)
) (
    input  logic [COUNT*ELEMENT_WIDTH-1:0] haystack,
    input  logic [ELEMENT_WIDTH-1:0]       needle,
    output logic                           found,
    output logic [IDX_W-1:0]               index
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if (haystack[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] == needle) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice slot allocator with round-robin stealing
module voice_allocator
    import dispatcher_pkg::*;
#(
    parameter int VOICE_COUNT    = 4,
    parameter int NOTE_WIDTH     = 7,
    parameter int VELOCITY_WIDTH = 7
) (
    input  logic                                clock,
    input  logic                                reset_l,
    input  logic                                event_valid,
    output logic                                event_ready,
    input  logic                                event_is_on,
    input  logic [NOTE_WIDTH-1:0]               event_note,
    input  logic [VELOCITY_WIDTH-1:0]           event_velocity,
    output logic [VOICE_COUNT-1:0]              voice_active,
    output logic [NOTE_WIDTH*VOICE_COUNT-1:0]     voice_note,
    output logic [VELOCITY_WIDTH*VOICE_COUNT-1:0] voice_velocity,
    output logic [VOICE_COUNT-1:0]              voice_trigger,
    output logic                                steal_pulse
);

    localparam int IDX_W = $clog2(VOICE_COUNT);
    localparam int KEY_W = NOTE_WIDTH + 1;

    alloc_state_e                         state_q, state_d;
    note_event_t                          ev_q, ev_d;
    logic                                 free_found_q, free_found_d;
    logic [IDX_W-1:0]                     free_idx_q, free_idx_d;
    logic                                 match_found_q, match_found_d;
    logic [IDX_W-1:0]                     match_idx_q, match_idx_d;
    logic [IDX_W-1:0]                     steal_ptr_q, steal_ptr_d;
    logic [VOICE_COUNT-1:0]               active_q, active_d;
    logic [NOTE_WIDTH*VOICE_COUNT-1:0]     note_q, note_d;
    logic [VELOCITY_WIDTH*VOICE_COUNT-1:0] vel_q, vel_d;
    logic [VOICE_COUNT-1:0]               trigger_q, trigger_d;
    logic                                 steal_q, steal_d;

    logic                                 free_found, match_found;
    logic [IDX_W-1:0]                     free_idx, match_idx;
    logic [KEY_W*VOICE_COUNT-1:0]          key_hay;
    logic [NOTE_WIDTH-1:0]                ev_note;
    logic [VELOCITY_WIDTH-1:0]            ev_vel;
    logic                                 ev_sounds;
    logic [IDX_W-1:0]                     slot;

    assign ev_note   = NOTE_WIDTH'(ev_q.note);
    assign ev_vel    = VELOCITY_WIDTH'(ev_q.velocity);
    // A note-on with zero velocity is a release in MIDI terms.
    assign ev_sounds = ev_q.is_on && (ev_vel != '0);

    assign event_ready    = reset_l && (state_q == ST_IDLE);
    assign voice_active   = active_q;
    assign voice_note     = note_q;
    assign voice_velocity = vel_q;
    assign voice_trigger  = trigger_q;
    assign steal_pulse    = steal_q;

    // Pair each slot's active flag with its note so a match only hits sounding voices.
    always_comb begin
        key_hay = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            key_hay[i*KEY_W +: KEY_W] = {active_q[i], note_q[i*NOTE_WIDTH +: NOTE_WIDTH]};
        end
    end

    search #(.ELEMENT_WIDTH(1), .COUNT(VOICE_COUNT)) u_free_search (
        .haystack (active_q),
        .needle   (1'b0),
        .found    (free_found),
        .index    (free_idx)
    );

    search #(.ELEMENT_WIDTH(KEY_W), .COUNT(VOICE_COUNT)) u_note_search (
        .haystack (key_hay),
        .needle   ({1'b1, ev_note}),
        .found    (match_found),
        .index    (match_idx)
    );

    // Next-state for the accept / search / commit sequence and the voice table.
    always_comb begin
        state_d       = state_q;
        ev_d          = ev_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        steal_ptr_d   = steal_ptr_q;
        active_d      = active_q;
        note_d        = note_q;
        vel_d         = vel_q;
        trigger_d     = '0;
        steal_d       = 1'b0;
        slot          = '0;
        case (state_q)
            ST_IDLE: begin
                if (event_valid) begin
                    ev_d.is_on    = event_is_on;
                    ev_d.note     = EV_NOTE_WIDTH'(event_note);
                    ev_d.velocity = EV_VELOCITY_WIDTH'(event_velocity);
                    state_d       = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                free_found_d  = free_found;
                free_idx_d    = free_idx;
                match_found_d = match_found;
                match_idx_d   = match_idx;
                state_d       = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (ev_sounds) begin
                    if (match_found_q) begin
                        slot = match_idx_q;
                    end else if (free_found_q) begin
                        slot = free_idx_q;
                    end else begin
                        slot        = steal_ptr_q;
                        steal_d     = 1'b1;
                        steal_ptr_d = steal_ptr_q + IDX_W'(1);
                    end
                    active_d[slot]                                  = 1'b1;
                    note_d[int'(slot)*NOTE_WIDTH +: NOTE_WIDTH]         = ev_note;
                    vel_d[int'(slot)*VELOCITY_WIDTH +: VELOCITY_WIDTH]  = ev_vel;
                    trigger_d[slot]                                 = 1'b1;
                end else if (match_found_q) begin
                    active_d[match_idx_q]                                   = 1'b0;
                    note_d[int'(match_idx_q)*NOTE_WIDTH +: NOTE_WIDTH]        = '0;
                    vel_d[int'(match_idx_q)*VELOCITY_WIDTH +: VELOCITY_WIDTH] = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register everything; reset drops any pending event and empties the table.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= ST_IDLE;
            ev_q          <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            steal_ptr_q   <= '0;
            active_q      <= '0;
            note_q        <= '0;
            vel_q         <= '0;
            trigger_q     <= '0;
            steal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ev_q          <= ev_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            steal_ptr_q   <= steal_ptr_d;
            active_q      <= active_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            trigger_q     <= trigger_d;
            steal_q       <= steal_d;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized and directed bench for voice_allocator
module tb_voice_allocator;

    localparam int VC = 4;
    localparam int NW = 7;
    localparam int VW = 7;

    logic              clock = 1'b0;
    logic              reset_l = 1'b0;
    logic              event_valid = 1'b0;
    logic              event_is_on = 1'b0;
    logic [NW-1:0]     event_note = '0;
    logic [VW-1:0]     event_velocity = '0;
    logic              event_ready;
    logic [VC-1:0]     voice_active;
    logic [NW*VC-1:0]  voice_note;
    logic [VW*VC-1:0]  voice_velocity;
    logic [VC-1:0]     voice_trigger;
    logic              steal_pulse;

    voice_allocator #(.VOICE_COUNT(VC), .NOTE_WIDTH(NW), .VELOCITY_WIDTH(VW)) dut (
        .clock          (clock),
        .reset_l        (reset_l),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_is_on    (event_is_on),
        .event_note     (event_note),
        .event_velocity (event_velocity),
        .voice_active   (voice_active),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_trigger  (voice_trigger),
        .steal_pulse    (steal_pulse)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an event-level voice table updated two edges after acceptance.
    int  m_active[VC];
    int  m_note[VC];
    int  m_vel[VC];
    int  m_trig[VC];
    int  m_ptr;
    int  m_steal;
    bit  m_pend;
    int  m_cnt;
    bit  m_is_on;
    int  m_n;
    int  m_v;
    logic m_ready_w;
    assign m_ready_w = reset_l && !m_pend;

    task automatic model_apply();
        int match;
        int free;
        int slot;
        match = -1;
        free  = -1;
        for (int i = VC - 1; i >= 0; i--) begin
            if (m_active[i] != 0 && m_note[i] == m_n) match = i;
            if (m_active[i] == 0) free = i;
        end
        if (m_is_on && m_v != 0) begin
            if (match >= 0) slot = match;
            else if (free >= 0) slot = free;
            else begin
                slot    = m_ptr;
                m_steal = 1;
                m_ptr   = (m_ptr + 1) % VC;
            end
            m_active[slot] = 1;
            m_note[slot]   = m_n;
            m_vel[slot]    = m_v;
            m_trig[slot]   = 1;
        end else if (match >= 0) begin
            m_active[match] = 0;
            m_note[match]   = 0;
            m_vel[match]    = 0;
        end
    endtask

    always @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < VC; i++) begin
                m_active[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_trig[i] = 0;
            end
            m_ptr = 0; m_steal = 0; m_pend = 0; m_cnt = 0;
        end else begin
            m_steal = 0;
            for (int i = 0; i < VC; i++) m_trig[i] = 0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    model_apply();
                    m_pend = 0;
                end
            end else if (event_valid) begin
                m_pend  = 1;
                m_cnt   = 2;
                m_is_on = event_is_on;
                m_n     = int'(event_note);
                m_v     = int'(event_velocity);
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    bit cmp_en = 1'b0;
    logic [VC-1:0] exp_act;
    logic [VC-1:0] exp_trig;
    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < VC; i++) begin
                exp_act[i]  = (m_active[i] != 0);
                exp_trig[i] = (m_trig[i] != 0);
            end
            chk("ready", event_ready, m_ready_w);
            chk("active", voice_active, exp_act);
            chk("trigger", voice_trigger, exp_trig);
            chk("steal", steal_pulse, m_steal);
            for (int i = 0; i < VC; i++) begin
                chk("note", voice_note[i*NW +: NW], m_note[i]);
                chk("velocity", voice_velocity[i*VW +: VW], m_vel[i]);
            end
        end
    end

    time t_accept;

    // Offer one event and hold it until accepted; returns just after the accept edge.
    task automatic send(input bit on, input int n, input int v);
        int waited;
        waited = 0;
        @(negedge clock);
        event_is_on    = on;
        event_note     = NW'(n);
        event_velocity = VW'(v);
        event_valid    = 1'b1;
        while (!event_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 20) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: event_ready stayed low for %0d cycles", waited);
        end
        @(posedge clock);
        t_accept = $time;
        #1;
        event_valid    = 1'b0;
        event_is_on    = 1'($urandom);
        event_note     = NW'($urandom);
        event_velocity = VW'($urandom);
    endtask

    task automatic to_commit();
        @(posedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        event_valid = 1'b0;
        @(posedge clock);
        #2 reset_l = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_ready", event_ready, 0);
        chk("rst_active", voice_active, 0);
        @(posedge clock);
        #2 reset_l = 1'b1;
    endtask

    task automatic chk_slot(input string name, input int s, input int n, input int v);
        chk(name, voice_note[s*NW +: NW], n);
        chk(name, voice_velocity[s*VW +: VW], v);
    endtask

    initial begin
        time t1;
        int gap;
        cmp_en = 1'b1;
        do_reset();

        // Single note-on lands in slot 0 two cycles after acceptance.
        send(1, 60, 100);
        to_commit();
        chk("first_trig", voice_trigger, 4'b0001);
        chk("first_active", voice_active, 4'b0001);
        chk_slot("first_slot0", 0, 60, 100);

        // Fill all slots, then steal round-robin from slot 0.
        do_reset();
        send(1, 60, 10); send(1, 62, 11); send(1, 64, 12); send(1, 67, 13);
        send(1, 69, 14);
        to_commit();
        chk("steal0_pulse", steal_pulse, 1);
        chk("steal0_trig", voice_trigger, 4'b0001);
        chk_slot("steal0_slot", 0, 69, 14);
        send(1, 71, 15);
        to_commit();
        chk("steal1_pulse", steal_pulse, 1);
        chk("steal1_trig", voice_trigger, 4'b0010);
        chk_slot("steal1_slot", 1, 71, 15);
        chk("steal1_active", voice_active, 4'b1111);

        // Release then reuse the lowest free slot.
        do_reset();
        send(1, 60, 50); send(1, 62, 51);
        send(0, 60, 0);
        to_commit();
        chk("off_active", voice_active, 4'b0010);
        chk_slot("off_slot0", 0, 0, 0);
        send(1, 65, 52);
        to_commit();
        chk("reuse_active", voice_active, 4'b0011);
        chk_slot("reuse_slot0", 0, 65, 52);

        // Retrigger of a sounding note reuses its slot without stealing.
        do_reset();
        send(1, 60, 100);
        send(1, 60, 30);
        to_commit();
        chk("retrig_trig", voice_trigger, 4'b0001);
        chk("retrig_steal", steal_pulse, 0);
        chk("retrig_active", voice_active, 4'b0001);
        chk_slot("retrig_slot0", 0, 60, 30);

        // Note-off of an absent note, then zero-velocity note-on as release.
        do_reset();
        send(1, 60, 40); send(1, 62, 41);
        send(0, 50, 9);
        to_commit();
        chk("absent_active", voice_active, 4'b0011);
        chk("absent_trig", voice_trigger, 0);
        chk("absent_steal", steal_pulse, 0);
        send(1, 62, 0);
        to_commit();
        chk("vel0_active", voice_active, 4'b0001);
        chk("vel0_trig", voice_trigger, 0);
        chk_slot("vel0_slot1", 1, 0, 0);

        // Back-to-back events are accepted every third cycle.
        send(1, 70, 1);
        t1 = t_accept;
        send(1, 71, 2);
        chk("b2b_spacing", 32'((t_accept - t1) / 10), 3);

        // Reset during SEARCH discards the pending note-on.
        do_reset();
        send(1, 60, 100);
        #2 reset_l = 1'b0;
        #1;
        chk("midrst_active", voice_active, 0);
        chk("midrst_trig", voice_trigger, 0);
        chk("midrst_ready", event_ready, 0);
        @(posedge clock);
        #2 reset_l = 1'b1;
        repeat (4) @(negedge clock);
        chk("midrst_empty", voice_active, 0);
        chk("midrst_ready_after", event_ready, 1);

        // Randomized traffic over a narrow note range to exercise matches and steals.
        for (int k = 0; k < 300; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clock);
            send(($urandom % 10) < 7, 58 + ($urandom % 8),
                 (($urandom % 6) == 0) ? 0 : $urandom_range(1, 127));
        end
        repeat (5) @(negedge clock);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
